// File: rtl/spi_slave_port.sv
// SPI target port (mode 3, MSB first, 8-bit bytes, active-low CS).
// All SPI pins are oversampled in the clk_48 domain; the CPU side sees a
// single-entry RX and a single-entry TX holding register with sticky flags.
module spi_slave_port #(
  parameter int          SYNC_STAGES   = 2,
  parameter logic [7:0]  UNDERRUN_BYTE = 8'hFF
) (
  input  logic       clk_48,
  input  logic       rst_n,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_empty,
  output logic       tx_underrun,
  input  logic       status_clr,
  output logic       frame_active,
  output logic       frame_start,
  output logic       frame_end,
  output logic [7:0] byte_cnt
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] r_csSync;
  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic                   r_csHist;
  logic                   r_sclkHist;

  logic [0:0] r_state;
  logic       r_frameStart;
  logic       r_frameEnd;
  logic [2:0] r_bitCnt;
  logic [7:0] r_byteCnt;

  logic       r_miso;
  logic       r_misoOe;
  logic [7:0] r_txShift;
  logic [7:0] r_txHold;
  logic       r_txEmpty;
  logic       r_txUnderrun;

  logic [7:0] r_rxShift;
  logic [7:0] r_rxData;
  logic       r_rxValid;
  logic       r_rxOverrun;

  logic       w_cs;
  logic       w_sclk;
  logic       w_mosi;
  logic       w_csFall;
  logic       w_csRise;
  logic       w_sclkFall;
  logic       w_sclkRise;
  logic       w_start;
  logic       w_stop;
  logic       w_fallAct;
  logic       w_riseAct;
  logic       w_load;
  logic       w_byteDone;
  logic [7:0] w_loadByte;

  // Synchronizer chains plus one history flop each for CS and SCLK edge detect
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      r_csSync   <= '1;
      r_sclkSync <= '1;
      r_mosiSync <= '1;
      r_csHist   <= 1'b1;
      r_sclkHist <= 1'b1;
    end else begin
      r_csSync   <= {r_csSync[SYNC_STAGES-2:0], spi_cs_n};
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], spi_sclk};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], spi_mosi};
      r_csHist   <= r_csSync[SYNC_STAGES-1];
      r_sclkHist <= r_sclkSync[SYNC_STAGES-1];
    end
  end

  assign w_cs       = r_csSync[SYNC_STAGES-1];
  assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
  assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
  assign w_csFall   = r_csHist & ~w_cs;
  assign w_csRise   = ~r_csHist & w_cs;
  assign w_sclkFall = r_sclkHist & ~w_sclk;
  assign w_sclkRise = ~r_sclkHist & w_sclk;
  assign w_start    = (r_state == ST_IDLE) & w_csFall;
  assign w_stop     = (r_state == ST_ACTIVE) & w_csRise;
  assign w_fallAct  = (r_state == ST_ACTIVE) & ~w_cs & w_sclkFall;
  assign w_riseAct  = (r_state == ST_ACTIVE) & ~w_cs & w_sclkRise;
  assign w_load     = w_fallAct & (r_bitCnt == 3'd0);
  assign w_byteDone = w_riseAct & (r_bitCnt == 3'd7);

  // Byte-boundary source: a same-cycle write bypasses the holding register
  always_comb begin
    w_loadByte = UNDERRUN_BYTE;
    if (tx_wr) begin
      w_loadByte = tx_data;
    end else if (!r_txEmpty) begin
      w_loadByte = r_txHold;
    end
  end

  // Frame state, frame pulses and bit/byte counters
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_frameStart <= 1'b0;
      r_frameEnd   <= 1'b0;
      r_bitCnt     <= 3'd0;
      r_byteCnt    <= 8'd0;
    end else begin
      r_frameStart <= w_start;
      r_frameEnd   <= w_stop;
      if (w_start) begin
        r_state   <= ST_ACTIVE;
        r_bitCnt  <= 3'd0;
        r_byteCnt <= 8'd0;
      end else if (w_stop) begin
        r_state  <= ST_IDLE;
        r_bitCnt <= 3'd0;
      end else if (w_riseAct) begin
        r_bitCnt <= r_bitCnt + 3'd1;
        if (w_byteDone && (r_byteCnt != 8'hFF)) begin
          r_byteCnt <= r_byteCnt + 8'd1;
        end
      end
    end
  end

  // MISO driver and transmit shifter, updated on SCLK falling edges
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      r_miso    <= 1'b1;
      r_misoOe  <= 1'b0;
      r_txShift <= 8'd0;
    end else if (w_start) begin
      r_miso   <= 1'b1;
      r_misoOe <= 1'b1;
    end else if (w_stop) begin
      r_miso   <= 1'b1;
      r_misoOe <= 1'b0;
    end else if (w_load) begin
      r_miso    <= w_loadByte[7];
      r_txShift <= {w_loadByte[6:0], 1'b0};
    end else if (w_fallAct) begin
      r_miso    <= r_txShift[7];
      r_txShift <= {r_txShift[6:0], 1'b0};
    end
  end

  // TX holding register with empty and sticky underrun flags
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      r_txHold     <= 8'd0;
      r_txEmpty    <= 1'b1;
      r_txUnderrun <= 1'b0;
    end else begin
      if (tx_wr) begin
        r_txHold <= tx_data;
      end
      if (w_load) begin
        r_txEmpty <= 1'b1;
      end else if (tx_wr) begin
        r_txEmpty <= 1'b0;
      end
      if (w_load && !tx_wr && r_txEmpty) begin
        r_txUnderrun <= 1'b1;
      end else if (status_clr) begin
        r_txUnderrun <= 1'b0;
      end
    end
  end

  // Receive shifter and RX holding register with sticky overrun flag
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      r_rxShift   <= 8'd0;
      r_rxData    <= 8'd0;
      r_rxValid   <= 1'b0;
      r_rxOverrun <= 1'b0;
    end else begin
      if (w_riseAct) begin
        r_rxShift <= {r_rxShift[6:0], w_mosi};
      end
      if (w_byteDone) begin
        r_rxData  <= {r_rxShift[6:0], w_mosi};
        r_rxValid <= 1'b1;
      end else if (rx_ack) begin
        r_rxValid <= 1'b0;
      end
      if (w_byteDone && r_rxValid && !rx_ack) begin
        r_rxOverrun <= 1'b1;
      end else if (status_clr) begin
        r_rxOverrun <= 1'b0;
      end
    end
  end

  assign spi_miso     = r_miso;
  assign spi_miso_oe  = r_misoOe;
  assign rx_data      = r_rxData;
  assign rx_valid     = r_rxValid;
  assign rx_overrun   = r_rxOverrun;
  assign tx_empty     = r_txEmpty;
  assign tx_underrun  = r_txUnderrun;
  assign frame_active = (r_state == ST_ACTIVE);
  assign frame_start  = r_frameStart;
  assign frame_end    = r_frameEnd;
  assign byte_cnt     = r_byteCnt;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: acts as a mode-3 SPI master at clk_48/8
// and as the CPU side, comparing against hand-computed expected values.
module tb_spi_slave_port;

  logic       clk_48 = 1'b0;
  logic       rst_n = 1'b1;
  logic       spi_cs_n = 1'b1;
  logic       spi_sclk = 1'b1;
  logic       spi_mosi = 1'b1;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       rx_overrun;
  logic [7:0] tx_data = 8'd0;
  logic       tx_wr = 1'b0;
  logic       tx_empty;
  logic       tx_underrun;
  logic       status_clr = 1'b0;
  logic       frame_active;
  logic       frame_start;
  logic       frame_end;
  logic [7:0] byte_cnt;

  int totalChecks = 0;
  int badChecks = 0;
  int startCount = 0;
  int endCount = 0;

  spi_slave_port #(.SYNC_STAGES(2), .UNDERRUN_BYTE(8'hFF)) dut (
    .clk_48(clk_48), .rst_n(rst_n),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack), .rx_overrun(rx_overrun),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_empty(tx_empty), .tx_underrun(tx_underrun),
    .status_clr(status_clr), .frame_active(frame_active),
    .frame_start(frame_start), .frame_end(frame_end), .byte_cnt(byte_cnt)
  );

  // 50 MHz stand-in for the 48 MHz system clock
  always #10 clk_48 = ~clk_48;

  // Count frame pulses on the opposite clock edge
  always @(negedge clk_48) begin
    if (frame_start) startCount++;
    if (frame_end) endCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_48);
    #1;
  endtask

  task automatic csLow();
    spi_cs_n = 1'b0;
    waitCycles(4);
  endtask

  task automatic csHigh();
    spi_cs_n = 1'b1;
    waitCycles(6);
  endtask

  task automatic txWrite(input logic [7:0] b);
    tx_data = b;
    tx_wr = 1'b1;
    waitCycles(1);
    tx_wr = 1'b0;
    waitCycles(1);
  endtask

  task automatic ackRx();
    rx_ack = 1'b1;
    waitCycles(1);
    rx_ack = 1'b0;
    waitCycles(1);
  endtask

  task automatic clearStatus();
    status_clr = 1'b1;
    waitCycles(1);
    status_clr = 1'b0;
    waitCycles(1);
  endtask

  // Shifts nBits of mosiByte (MSB first), 4 clocks per SCLK phase. Optional
  // rx_ack lands on the cycle the last rise is acted on, optional tx_wr on
  // the cycle the first fall loads the byte; MISO is sampled before each rise.
  task automatic applyStimulus(input logic [7:0] mosiByte, input int nBits,
                               input bit ackOnLast, input bit wrOnFirst,
                               input logic [7:0] wrByte, output logic [7:0] misoByte);
    misoByte = 8'd0;
    for (int i = 7; i >= 8 - nBits; i--) begin
      spi_sclk = 1'b0;
      spi_mosi = mosiByte[i];
      if (i == 7 && wrOnFirst) begin
        waitCycles(2);
        tx_data = wrByte;
        tx_wr = 1'b1;
        waitCycles(1);
        tx_wr = 1'b0;
        waitCycles(1);
      end else begin
        waitCycles(4);
      end
      misoByte[i] = spi_miso;
      spi_sclk = 1'b1;
      if (i == 0 && ackOnLast) begin
        waitCycles(2);
        rx_ack = 1'b1;
        waitCycles(1);
        rx_ack = 1'b0;
        waitCycles(1);
      end else begin
        waitCycles(4);
      end
    end
  endtask

  initial begin
    logic [7:0] misoByte;
    int startBase;
    int endBase;

    // Reset values
    #2 rst_n = 1'b0;
    waitCycles(2);
    checkOutput("rst_miso", spi_miso, 1);
    checkOutput("rst_oe", spi_miso_oe, 0);
    checkOutput("rst_rxdata", rx_data, 0);
    checkOutput("rst_rxvalid", rx_valid, 0);
    checkOutput("rst_txempty", tx_empty, 1);
    checkOutput("rst_bytecnt", byte_cnt, 0);
    checkOutput("rst_active", frame_active, 0);
    rst_n = 1'b1;
    waitCycles(3);

    // One-byte frame: send 3C, receive A5
    startBase = startCount;
    endBase = endCount;
    txWrite(8'hA5);
    checkOutput("t1_txempty_wr", tx_empty, 0);
    csLow();
    checkOutput("t1_active", frame_active, 1);
    checkOutput("t1_oe", spi_miso_oe, 1);
    applyStimulus(8'h3C, 8, 1'b0, 1'b0, 8'h00, misoByte);
    checkOutput("t1_miso", misoByte, 8'hA5);
    checkOutput("t1_rxdata", rx_data, 8'h3C);
    checkOutput("t1_rxvalid", rx_valid, 1);
    csHigh();
    checkOutput("t1_bytecnt", byte_cnt, 1);
    checkOutput("t1_starts", startCount - startBase, 1);
    checkOutput("t1_ends", endCount - endBase, 1);
    checkOutput("t1_txempty", tx_empty, 1);
    checkOutput("t1_underrun", tx_underrun, 0);
    checkOutput("t1_oe_off", spi_miso_oe, 0);
    ackRx();
    checkOutput("t1_ack", rx_valid, 0);

    // Three-byte frame with no TX data, acked after each byte
    csLow();
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(8'(k), 8, 1'b0, 1'b0, 8'h00, misoByte);
      checkOutput("t2_miso", misoByte, 8'hFF);
      checkOutput("t2_rxdata", rx_data, k);
      checkOutput("t2_underrun", tx_underrun, 1);
      ackRx();
    end
    checkOutput("t2_bytecnt", byte_cnt, 3);
    checkOutput("t2_overrun", rx_overrun, 0);
    checkOutput("t2_rxvalid", rx_valid, 0);
    csHigh();

    // Two bytes without ack -> overrun, then status clear
    csLow();
    applyStimulus(8'h11, 8, 1'b0, 1'b0, 8'h00, misoByte);
    checkOutput("t3_overrun_first", rx_overrun, 0);
    applyStimulus(8'h22, 8, 1'b0, 1'b0, 8'h00, misoByte);
    checkOutput("t3_rxdata", rx_data, 8'h22);
    checkOutput("t3_overrun", rx_overrun, 1);
    checkOutput("t3_bytecnt", byte_cnt, 2);
    csHigh();
    clearStatus();
    checkOutput("t3_clr_overrun", rx_overrun, 0);
    checkOutput("t3_clr_underrun", tx_underrun, 0);
    checkOutput("t3_rxvalid", rx_valid, 1);

    // Same-cycle rx_ack on completion and tx_wr on the boundary load
    csLow();
    applyStimulus(8'h96, 8, 1'b1, 1'b1, 8'h5A, misoByte);
    checkOutput("t4_miso", misoByte, 8'h5A);
    checkOutput("t4_rxdata", rx_data, 8'h96);
    checkOutput("t4_rxvalid", rx_valid, 1);
    checkOutput("t4_overrun", rx_overrun, 0);
    checkOutput("t4_txempty", tx_empty, 1);
    checkOutput("t4_underrun", tx_underrun, 0);
    csHigh();
    ackRx();

    // CS rises after four bits; the next frame's byte is intact
    endBase = endCount;
    csLow();
    applyStimulus(8'hF0, 4, 1'b0, 1'b0, 8'h00, misoByte);
    csHigh();
    checkOutput("t5_end", endCount - endBase, 1);
    checkOutput("t5_rxvalid", rx_valid, 0);
    checkOutput("t5_oe", spi_miso_oe, 0);
    checkOutput("t5_rxdata_kept", rx_data, 8'h96);
    clearStatus();
    csLow();
    applyStimulus(8'hC3, 8, 1'b0, 1'b0, 8'h00, misoByte);
    checkOutput("t5_rxdata", rx_data, 8'hC3);
    checkOutput("t5_bytecnt", byte_cnt, 1);
    csHigh();

    // Reset asserted mid-frame
    csLow();
    applyStimulus(8'h77, 8, 1'b0, 1'b0, 8'h00, misoByte);
    txWrite(8'h42);
    applyStimulus(8'hE0, 3, 1'b0, 1'b0, 8'h00, misoByte);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_miso", spi_miso, 1);
    checkOutput("t6_oe", spi_miso_oe, 0);
    checkOutput("t6_rxdata", rx_data, 0);
    checkOutput("t6_rxvalid", rx_valid, 0);
    checkOutput("t6_overrun", rx_overrun, 0);
    checkOutput("t6_txempty", tx_empty, 1);
    checkOutput("t6_underrun", tx_underrun, 0);
    checkOutput("t6_active", frame_active, 0);
    checkOutput("t6_bytecnt", byte_cnt, 0);
    waitCycles(1);
    spi_cs_n = 1'b1;
    rst_n = 1'b1;
    waitCycles(6);
    txWrite(8'hE7);
    csLow();
    applyStimulus(8'h81, 8, 1'b0, 1'b0, 8'h00, misoByte);
    checkOutput("t6_post_miso", misoByte, 8'hE7);
    checkOutput("t6_post_rxdata", rx_data, 8'h81);
    checkOutput("t6_post_bytecnt", byte_cnt, 1);
    csHigh();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
